// File: rtl/lite_master_ctrl.sv
// Single-outstanding lite-bus master: turns one command into one AW/W or AR/R
// transaction and returns a response, with a watchdog for unresponsive slaves.
module lite_master_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    // command / response
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic                    rsp_err,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    // slave channels
    output logic                    awvalid,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wvalid,
    input  logic                    wready,
    output logic                    arvalid,
    output logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    arready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic                    rvalid,
    output logic                    rready
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    localparam logic [CNT_WIDTH-1:0] WD_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] wd_cnt;
    logic                 cmd_acc;
    logic                 wr_done;
    logic                 rd_done;
    logic                 expire;

    assign cmd_ready = (state == IDLE);
    assign cmd_acc   = cmd_valid && cmd_ready;

    // A channel whose valid has already dropped finished its handshake earlier.
    assign wr_done = (!awvalid || awready) && (!wvalid || wready);
    // R is only taken in or after the AR handshake cycle; rready is 1 in READ.
    assign rd_done = rvalid && rready && (!arvalid || arready);
    assign expire  = (TIMEOUT_CYCLES != 0) && (wd_cnt == WD_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (cmd_acc) state_nxt = cmd_write ? WRITE : READ;
            WRITE: if (wr_done || expire) state_nxt = RESP;
            READ:  if (rd_done || expire) state_nxt = RESP;
            RESP:  if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            rsp_valid <= 1'b0;
            awaddr    <= '0;
            araddr    <= '0;
            wdata     <= '0;
            wstrb     <= '0;
            rsp_rdata <= '0;
            rsp_write <= 1'b0;
            rsp_err   <= 1'b0;
            wd_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_acc) begin
                        wd_cnt <= '0;
                        if (cmd_write) begin
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            awaddr  <= cmd_addr;
                            wdata   <= cmd_wdata;
                            wstrb   <= cmd_wstrb;
                        end else begin
                            arvalid <= 1'b1;
                            rready  <= 1'b1;
                            araddr  <= cmd_addr;
                        end
                    end
                end
                WRITE: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (awvalid && awready) awvalid <= 1'b0;
                    if (wvalid && wready)   wvalid  <= 1'b0;
                    if (wr_done || expire) begin
                        // completion wins over expiry in the same cycle
                        awvalid   <= 1'b0;
                        wvalid    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b1;
                        rsp_err   <= !wr_done;
                        rsp_rdata <= '0;
                    end
                end
                READ: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (arvalid && arready) arvalid <= 1'b0;
                    if (rd_done || expire) begin
                        arvalid   <= 1'b0;
                        rready    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b0;
                        rsp_err   <= !rd_done;
                        rsp_rdata <= rd_done ? rdata : '0;
                    end
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lite_master_ctrl.sv
// Randomized bench for lite_master_ctrl: per-transaction slave delays are drawn
// at random and the expected outcome is computed from the handshake/timeout rules.
module tb_lite_master_ctrl;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int T  = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_write, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
    logic [AW-1:0] awaddr, araddr;
    logic [DW-1:0] wdata, rdata;
    logic [3:0]    wstrb;

    int n_chk  = 0;
    int n_pass = 0;

    lite_master_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T), .CNT_WIDTH(16)
    ) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .arvalid(arvalid), .araddr(araddr), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input longint unsigned act, input longint unsigned exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic slave_idle();
        awready = 1'b0; wready = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = '0;
    endtask

    // da/db: cycles after valids rise before the slave's first/second ready
    // (write: awready/wready; read: arready/rvalid). rdata on a beat is data^cycle.
    task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [3:0] strb, input int da, input int db, input int hold);
        int comp, last, k, c_a, c_b, c_rr;
        bit err, seen;
        logic [DW-1:0] exp_rd, hold_rd;
        comp   = (da > db) ? da : db;
        err    = comp > T - 1;
        last   = err ? T - 1 : comp;
        exp_rd = (wr || err) ? '0 : (data ^ DW'(comp));

        @(negedge CLK);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        @(negedge CLK);
        // garbage on the command bus while busy must be ignored
        cmd_valid = 1'b1; cmd_write = ~wr; cmd_addr = AW'($urandom); cmd_wdata = $urandom;
        k = 0; seen = 0; c_a = 0; c_b = 0; c_rr = 0;
        while (!seen && k < T + 4) begin
            if (rsp_valid) seen = 1;
            else begin
                if (k == 0) begin
                    chk("cmd_ready_busy", cmd_ready, 0);
                    if (wr) begin
                        chk("awaddr", awaddr, addr);
                        chk("wdata", wdata, data);
                        chk("wstrb", wstrb, strb);
                    end else chk("araddr", araddr, addr);
                end
                if (wr) begin c_a += int'(awvalid); c_b += int'(wvalid); end
                else begin c_a += int'(arvalid); c_rr += int'(rready); end
                awready = wr && k >= da;
                wready  = wr && k >= db;
                arready = !wr && k >= da;
                rvalid  = !wr && k >= db;
                rdata   = rvalid ? (data ^ DW'(k)) : DW'($urandom);
                @(negedge CLK);
                k++;
            end
        end
        slave_idle();
        cmd_valid = 1'b0;
        chk("rsp_seen", seen, 1);
        chk("rsp_latency", k, last + 1);
        chk("rsp_write", rsp_write, wr);
        chk("rsp_err", rsp_err, err);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("a_valid_cycles", c_a, ((da < T - 1) ? da : T - 1) + 1);
        if (wr) chk("wvalid_cycles", c_b, ((db < T - 1) ? db : T - 1) + 1);
        else    chk("rready_cycles", c_rr, last + 1);
        chk("valids_low", {awvalid, wvalid, arvalid, rready}, 0);
        hold_rd = rsp_rdata;
        rsp_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge CLK);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_rdata", rsp_rdata, hold_rd);
            chk("hold_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge CLK);
        rsp_ready = 1'b0;
        chk("rsp_dropped", rsp_valid, 0);
        chk("cmd_ready_after", cmd_ready, 1);
    endtask

    initial begin
        RST = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_wstrb = '0; rsp_ready = 1'b0;
        slave_idle();
        #3;
        chk("rst_valids", {awvalid, wvalid, arvalid, rready, rsp_valid}, 0);
        chk("rst_data", {awaddr, araddr, wdata, wstrb, rsp_rdata, rsp_write, rsp_err}, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        @(negedge CLK); @(negedge CLK);
        RST = 1'b0;

        // directed cases
        run_txn(1, 12'h010, 32'hA5, 4'hF, 2, 2, 0);
        run_txn(1, 12'h020, 32'h1234, 4'h3, 3, 0, 1);
        run_txn(0, 12'h000, 32'h5A, 4'h0, 0, 0, 0);
        run_txn(0, 12'h004, 32'hCAFE, 4'h0, 1, 2, 5);
        run_txn(0, 12'h008, 32'hBEEF, 4'h0, 100, 100, 0);
        run_txn(0, 12'h00C, 32'h77, 4'h0, 0, 0 + 3, 0);
        run_txn(0, 12'h00C, 32'h99, 4'h0, 4, 0, 0);
        run_txn(0, 12'h010, 32'h11, 4'h0, T - 1, 0, 0);
        run_txn(0, 12'h010, 32'h22, 4'h0, 0, T, 0);
        run_txn(1, 12'h030, 32'h33, 4'h1, 0, T - 1, 0);
        run_txn(1, 12'h034, 32'h44, 4'h2, T, 1, 2);

        // reset while a write is pending
        @(negedge CLK);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h040; cmd_wdata = 32'hDEAD; cmd_wstrb = 4'hF;
        @(negedge CLK);
        cmd_valid = 1'b0;
        @(negedge CLK); @(negedge CLK);
        chk("pre_rst_awvalid", awvalid, 1);
        #2 RST = 1'b1;
        #1;
        chk("mid_rst_valids", {awvalid, wvalid, rsp_valid}, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("post_rst_no_rsp", rsp_valid, 0);
        run_txn(1, 12'h044, 32'hF00D, 4'hF, 1, 1, 0);

        // random traffic
        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom), AW'($urandom), $urandom, 4'($urandom),
                    int'($urandom_range(0, T + 1)), int'($urandom_range(0, T + 1)),
                    int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
